multiport_register_file: RTL

//  Parametrised register file for the datapath: N read ports, M write ports, configurable width/depth.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_ctrl.sv | 61 ++++++
 rtl/multiport_register_file.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    // Number of entries addressed by an addr_w-bit address.
    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: sweeps every entry to zero after reset or on request,
// then idles with ready high until the next clear request.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and outputs; the last entry (all-ones address) ends the sweep.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_o    = 1'b0;
        clr_we_o   = 1'b0;
        clr_addr_o = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                clr_we_o = 1'b1;
                if (cnt_q == '1) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RF_IDLE: begin
                ready_o = 1'b1;
                if (clr_i) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file: NUM_RD async read ports, NUM_WR sync write ports,
// optional hardwired-zero entry 0, hardware clear sweep and write-conflict flag.
// Optional feature: define RF_BYPASS_EN for write-first (same-cycle) read bypass;
// undefined gives read-first behaviour.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    output logic                     ready,
    output logic                     wr_conflict
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [NUM_WR-1:0] wr_ok;
    logic              conflict_d;
    logic              wr_conflict_q;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Qualify each write port: only in IDLE, and never to a hardwired-zero entry 0.
    always_comb begin
        wr_ok = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = we[j] && ready &&
                       !((ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Flag any pair of qualified write ports that target the same entry.
    always_comb begin
        conflict_d = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            for (int unsigned k = j + 1; k < NUM_WR; k++) begin
                if (wr_ok[j] && wr_ok[k] &&
                    (wa[j*ADDR_W +: ADDR_W] == wa[k*ADDR_W +: ADDR_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Conflict flag holds for exactly the cycle after the colliding writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    // Storage update: the sweep owns the array while clearing; otherwise ports are
    // applied in ascending order so the highest-index port wins on collisions.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) begin
                    mem_q[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read muxes: zero while clearing or for hardwired entry 0; optional write-first bypass.
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd[i*DATA_W +: DATA_W] = mem_q[ra[i*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j] && (wa[j*ADDR_W +: ADDR_W] == ra[i*ADDR_W +: ADDR_W])) begin
                    rd[i*DATA_W +: DATA_W] = wd[j*DATA_W +: DATA_W];
                end
            end
`endif
            if (!ready || ((ZERO_REG != 0) && (ra[i*ADDR_W +: ADDR_W] == '0))) begin
                rd[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule
